aes_job_arbiter: RTL and testbench

- Shares one AESProcessor core between two requesters (A, B).
- Accepts jobs over a REQ/ACK handshake and arbitrates round-robin.
- Sequences the core's one-cycle START pulse with KEY/TEXTIN/ENCDEC, waits for DONE, and returns TEXTOUT to the winning requester over a VALID/RDY handshake.
- Sits between the host-side job sources and the AES core; the core keeps its own nRST, driven externally.

---
 rtl/aes_job_arbiter.sv | 156 +++++++++++++++
 tb/tb_aes_job_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES core between requesters A and B.
// Optional WAIT-state watchdog enabled by defining AES_TIMEOUT_EN.
module aes_job_arbiter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_A,
  input  logic             REQ_B,
  input  logic             ENCDEC_A,
  input  logic             ENCDEC_B,
  input  logic [127:0]     KEY_A,
  input  logic [127:0]     KEY_B,
  input  logic [127:0]     TEXT_A,
  input  logic [127:0]     TEXT_B,
  output logic             ACK_A,
  output logic             ACK_B,
  output logic             VALID_A,
  output logic             VALID_B,
  input  logic             RDY_A,
  input  logic             RDY_B,
  output logic [127:0]     RESULT,
  output logic             ERR,
  output logic             CORE_START,
  output logic             CORE_ENCDEC,
  output logic [127:0]     CORE_KEY,
  output logic [127:0]     CORE_TEXTIN,
  input  logic             CORE_DONE,
  input  logic [127:0]     CORE_TEXTOUT,
  output logic [CNT_W-1:0] JOBS_DONE,
  output logic             BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic               r_prio_b;
  logic               r_gnt_b;
  logic               r_ack_a, r_ack_b;
  logic               r_valid_a, r_valid_b;
  logic               r_start;
  logic               r_encdec;
  logic [127:0]       r_key, r_text, r_result;
  logic [CNT_W-1:0]   r_jobs;
  logic               r_busy;
  logic               w_pick_b;
  logic               w_rdy;

`ifdef AES_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_err;
  assign ERR = r_err;
`else
  logic               w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT < 0);
  assign ERR = 1'b0;
`endif

  // B wins only when it is alone or the pointer favours it on a tie
  assign w_pick_b = REQ_B && (!REQ_A || r_prio_b);
  assign w_rdy    = r_gnt_b ? RDY_B : RDY_A;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_prio_b  <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
      r_start   <= 1'b0;
      r_encdec  <= 1'b0;
      r_key     <= '0;
      r_text    <= '0;
      r_result  <= '0;
      r_jobs    <= '0;
      r_busy    <= 1'b0;
`ifdef AES_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (REQ_A || REQ_B) begin
            r_gnt_b  <= w_pick_b;
            r_key    <= w_pick_b ? KEY_B    : KEY_A;
            r_text   <= w_pick_b ? TEXT_B   : TEXT_A;
            r_encdec <= w_pick_b ? ENCDEC_B : ENCDEC_A;
            r_ack_a  <= !w_pick_b;
            r_ack_b  <= w_pick_b;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_start <= 1'b1;
          r_state <= S_WAIT;
`ifdef AES_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // DONE coincident with our own START pulse is never a real completion
          if (!r_start && CORE_DONE) begin
            r_result  <= CORE_TEXTOUT;
            r_valid_a <= !r_gnt_b;
            r_valid_b <= r_gnt_b;
            r_state   <= S_RESP;
`ifdef AES_TIMEOUT_EN
            r_err     <= 1'b0;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            r_result  <= '0;
            r_err     <= 1'b1;
            r_valid_a <= !r_gnt_b;
            r_valid_b <= r_gnt_b;
            r_state   <= S_RESP;
          end else begin
            r_to_cnt  <= r_to_cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          if (w_rdy) begin
            r_valid_a <= 1'b0;
            r_valid_b <= 1'b0;
            r_jobs    <= r_jobs + 1'b1;
            r_prio_b  <= !r_gnt_b;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ACK_A       = r_ack_a;
  assign ACK_B       = r_ack_b;
  assign VALID_A     = r_valid_a;
  assign VALID_B     = r_valid_b;
  assign RESULT      = r_result;
  assign CORE_START  = r_start;
  assign CORE_ENCDEC = r_encdec;
  assign CORE_KEY    = r_key;
  assign CORE_TEXTIN = r_text;
  assign JOBS_DONE   = r_jobs;
  assign BUSY        = r_busy;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter: directed scenarios plus randomized jobs against a transaction-level model.
// Define AES_TIMEOUT_EN for both files to include the watchdog scenario.
module tb_aes_job_arbiter;

  localparam int CNT_W = 16;
  localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C0 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             REQ_A = 1'b0, REQ_B = 1'b0;
  logic             ENCDEC_A = 1'b0, ENCDEC_B = 1'b0;
  logic [127:0]     KEY_A = '0, KEY_B = '0, TEXT_A = '0, TEXT_B = '0;
  logic             ACK_A, ACK_B, VALID_A, VALID_B;
  logic             RDY_A = 1'b0, RDY_B = 1'b0;
  logic [127:0]     RESULT;
  logic             ERR;
  logic             CORE_START, CORE_ENCDEC;
  logic [127:0]     CORE_KEY, CORE_TEXTIN;
  logic             CORE_DONE;
  logic [127:0]     CORE_TEXTOUT;
  logic [CNT_W-1:0] JOBS_DONE;
  logic             BUSY;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state
  bit m_prio_b = 1'b0;
  int m_jobs   = 0;

  // Core stand-in
  bit           core_en    = 1'b1;
  logic         stray_done = 1'b0;
  logic         cm_done    = 1'b0;
  logic [127:0] cm_out     = '0;
  int           cm_cnt     = 0;
  logic         prev_start = 1'b0;

  assign CORE_DONE    = cm_done | stray_done;
  assign CORE_TEXTOUT = cm_out;

  aes_job_arbiter #(.CNT_W(CNT_W), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .ENCDEC_A(ENCDEC_A), .ENCDEC_B(ENCDEC_B),
    .KEY_A(KEY_A), .KEY_B(KEY_B), .TEXT_A(TEXT_A), .TEXT_B(TEXT_B),
    .ACK_A(ACK_A), .ACK_B(ACK_B), .VALID_A(VALID_A), .VALID_B(VALID_B),
    .RDY_A(RDY_A), .RDY_B(RDY_B), .RESULT(RESULT), .ERR(ERR),
    .CORE_START(CORE_START), .CORE_ENCDEC(CORE_ENCDEC),
    .CORE_KEY(CORE_KEY), .CORE_TEXTIN(CORE_TEXTIN),
    .CORE_DONE(CORE_DONE), .CORE_TEXTOUT(CORE_TEXTOUT),
    .JOBS_DONE(JOBS_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Known AES-128 vector both ways; any other input maps through an invertible stand-in
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] txt, input logic dec);
    if (key == K0 && !dec && txt == P0) return C0;
    if (key == K0 &&  dec && txt == C0) return P0;
    return txt ^ {key[63:0], key[127:64]} ^ {128{dec}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) begin
    cm_done <= 1'b0;
    if (core_en && CORE_START) begin
      cm_cnt <= $urandom_range(1, 5);
      cm_out <= aes_ref(CORE_KEY, CORE_TEXTIN, CORE_ENCDEC);
    end else if (cm_cnt != 0) begin
      cm_cnt <= cm_cnt - 1;
      if (cm_cnt == 1) cm_done <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("ack_excl", ACK_A & ACK_B, 0);
      chk("valid_excl", VALID_A & VALID_B, 0);
      chk("start_1cyc", CORE_START & prev_start, 0);
    end
    prev_start = CORE_START;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0; RDY_A = 1'b0; RDY_B = 1'b0;
    tick();
    RST = 1'b0;
    m_prio_b = 1'b0;
    m_jobs   = 0;
  endtask

  // One job through the arbiter; caller sets REQ/KEY/TEXT/ENCDEC beforehand and DUT is idle
  task automatic do_job(input int rdy_dly, input bit keep_loser,
                        output logic [127:0] res, output bit who_b);
    bit           wb;
    logic [127:0] exp, ekey, etxt;
    logic         eenc;
    int           n;
    wb   = (REQ_A && REQ_B) ? m_prio_b : REQ_B;
    ekey = wb ? KEY_B : KEY_A;
    etxt = wb ? TEXT_B : TEXT_A;
    eenc = wb ? ENCDEC_B : ENCDEC_A;
    exp  = aes_ref(ekey, etxt, eenc);
    tick();
    chk("ack_a", ACK_A, !wb);
    chk("ack_b", ACK_B, wb);
    chk("busy_on", BUSY, 1);
    if (wb) REQ_B = 1'b0; else REQ_A = 1'b0;
    if (!keep_loser) begin REQ_A = 1'b0; REQ_B = 1'b0; end
    if (rdy_dly == 0) begin if (wb) RDY_B = 1'b1; else RDY_A = 1'b1; end
    tick();
    chk("start", CORE_START, 1);
    chk("ack_pulse", {ACK_A, ACK_B}, 0);
    chk("core_key", CORE_KEY, ekey);
    chk("core_text", CORE_TEXTIN, etxt);
    chk("core_enc", CORE_ENCDEC, eenc);
    n = 0;
    while (!(VALID_A || VALID_B) && n < 60) begin
      chk("no_ack_busy", {ACK_A, ACK_B}, 0);
      tick();
      n++;
    end
    chk("valid_seen", (n < 60), 1);
    chk("valid_a", VALID_A, !wb);
    chk("valid_b", VALID_B, wb);
    chk("result", RESULT, exp);
    chk("err", ERR, 0);
    res   = RESULT;
    who_b = wb;
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("hold_valid", wb ? VALID_B : VALID_A, 1);
      chk("hold_result", RESULT, exp);
      chk("no_ack_resp", {ACK_A, ACK_B}, 0);
    end
    if (rdy_dly > 0) begin if (wb) RDY_B = 1'b1; else RDY_A = 1'b1; end
    tick();
    m_jobs++;
    m_prio_b = !wb;
    chk("valid_drop", {VALID_A, VALID_B}, 0);
    chk("jobs", JOBS_DONE, CNT_W'(m_jobs));
    chk("busy_off", BUSY, 0);
    RDY_A = 1'b0; RDY_B = 1'b0;
  endtask

  logic [127:0] res;
  bit           wb;
  bit           order[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    do_reset();
    RST = 1'b1;
    tick();
    chk("rst_outs", {ACK_A, ACK_B, VALID_A, VALID_B, ERR, CORE_START, CORE_ENCDEC, BUSY}, 0);
    chk("rst_vec", RESULT | CORE_KEY | CORE_TEXTIN, 0);
    chk("rst_jobs", JOBS_DONE, 0);
    RST = 1'b0;

    // Single encrypt on A, then decrypt round-trip on B
    REQ_A = 1'b1; KEY_A = K0; TEXT_A = P0; ENCDEC_A = 1'b0;
    do_job(0, 0, res, wb);
    chk("enc_vec", res, C0);
    chk("enc_jobs", JOBS_DONE, 1);
    REQ_B = 1'b1; KEY_B = K0; TEXT_B = C0; ENCDEC_B = 1'b1;
    do_job(2, 0, res, wb);
    chk("dec_vec", res, P0);
    chk("dec_side", wb, 1);

    // Both held for four jobs
    do_reset();
    KEY_A = {4{$urandom}}; TEXT_A = {4{$urandom}};
    KEY_B = {4{$urandom}}; TEXT_B = {4{$urandom}};
    for (int j = 0; j < 4; j++) begin
      REQ_A = 1'b1; REQ_B = 1'b1;
      do_job(j, 1, res, wb);
      order[j] = wb;
    end
    chk("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
    chk("rr_jobs", JOBS_DONE, 4);

    // Back-pressure on A with B waiting, then B goes immediately
    REQ_A = 1'b1; REQ_B = 1'b1;
    do_job(10, 1, res, wb);
    chk("bp_first", wb, 0);
    do_job(0, 0, res, wb);
    chk("bp_second", wb, 1);

    // Reset mid-WAIT discards the job
    REQ_A = 1'b1; KEY_A = {4{$urandom}};
    tick();
    REQ_A = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_prio_b = 1'b0; m_jobs = 0;
    chk("rstw_outs", {ACK_A, ACK_B, VALID_A, VALID_B, ERR, CORE_START, CORE_ENCDEC, BUSY}, 0);
    chk("rstw_vec", RESULT | CORE_KEY | CORE_TEXTIN, 0);
    chk("rstw_jobs", JOBS_DONE, 0);
    for (int i = 0; i < 10; i++) begin
      stray_done = (i == 7);
      tick();
      chk("rstw_novalid", {VALID_A, VALID_B, BUSY}, 0);
    end
    stray_done = 1'b0;
    chk("rstw_jobs_end", JOBS_DONE, 0);

`ifdef AES_TIMEOUT_EN
    // Core never answers: watchdog fires after 8 WAIT cycles
    core_en = 1'b0;
    REQ_A = 1'b1;
    tick();
    REQ_A = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_early", {VALID_A, VALID_B}, 0);
    end
    tick();
    chk("to_valid", VALID_A, 1);
    chk("to_err", ERR, 1);
    chk("to_result", RESULT, 0);
    RDY_A = 1'b1;
    tick();
    RDY_A = 1'b0;
    m_jobs++; m_prio_b = 1'b1;
    chk("to_jobs", JOBS_DONE, CNT_W'(m_jobs));
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    chk("to_late_done", {VALID_A, VALID_B, BUSY}, 0);
    core_en = 1'b1;
`endif

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (!REQ_A && $urandom_range(0, 1)) begin
        REQ_A = 1'b1; KEY_A = {$urandom, $urandom, $urandom, $urandom};
        TEXT_A = {$urandom, $urandom, $urandom, $urandom}; ENCDEC_A = 1'($urandom);
      end
      if (!REQ_B && $urandom_range(0, 1)) begin
        REQ_B = 1'b1; KEY_B = {$urandom, $urandom, $urandom, $urandom};
        TEXT_B = {$urandom, $urandom, $urandom, $urandom}; ENCDEC_B = 1'($urandom);
      end
      if (!REQ_A && !REQ_B) begin
        REQ_A = 1'b1; TEXT_A = {$urandom, $urandom, $urandom, $urandom};
      end
      do_job($urandom_range(0, 4), 1'($urandom), res, wb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
